ram_dp_init: RTL and testbench

Simple dual-port synchronous RAM: one write port and one read port, both on the same clock. Adds per-lane write masking, a selectable read-during-write mode, a registered read-valid strobe and a hardware clear sequencer that initialises every word after reset. It is the parametrised successor to the single-port register-file RAM, for buffers and lookup tables that need simultaneous read and write and a known power-up content.

---
 rtl/ram_pkg.sv | 34 +++
 rtl/ram_dp_init_if.sv | 28 ++
 rtl/ram_clear_seq.sv | 46 ++++
 rtl/ram_dp_init.sv | 78 +++++++
 tb/tb_ram_dp_init.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared types, constants and lane-merge helper for the dual-port init RAM.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ram_state_t;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

  // Upper bound on word width handled by lane_merge; callers cast in and out.
  localparam int unsigned MAX_BITS = 256;

  // Per-lane merge: lane i of the result comes from new_word when mask[i] is set.
  function automatic logic [MAX_BITS-1:0] lane_merge(
    input logic [MAX_BITS-1:0] old_word,
    input logic [MAX_BITS-1:0] new_word,
    input logic [MAX_BITS-1:0] mask,
    input int unsigned         lane_bits
  );
    logic [MAX_BITS-1:0] merged;
    logic [7:0]          lane_idx;
    logic [7:0]          bit_idx;
    merged = old_word;
    for (int unsigned b = 0; b < MAX_BITS; b++) begin
      bit_idx  = 8'(b);
      lane_idx = 8'(b / lane_bits);
      if (mask[lane_idx]) merged[bit_idx] = new_word[bit_idx];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_dp_init_if.sv
// Request/response bundle for ram_dp_init: write port, read port and status.
interface ram_dp_init_if #(
  parameter int unsigned DATA_BITS    = 16,
  parameter int unsigned LANE_BITS    = 8,
  parameter int unsigned ADDRESS_BITS = 4
);
  localparam int unsigned LANES = DATA_BITS / LANE_BITS;

  logic                    ready;
  logic                    write;
  logic [ADDRESS_BITS-1:0] write_addr;
  logic [LANES-1:0]        write_mask;
  logic [DATA_BITS-1:0]    in_data;
  logic                    read;
  logic [ADDRESS_BITS-1:0] read_addr;
  logic [DATA_BITS-1:0]    out_data;
  logic                    out_valid;

  modport master (
    input  ready, out_data, out_valid,
    output write, write_addr, write_mask, in_data, read, read_addr
  );

  modport slave (
    output ready, out_data, out_valid,
    input  write, write_addr, write_mask, in_data, read, read_addr
  );
endinterface

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, then enables user access.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int unsigned ADDRESS_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    ready,
  output logic                    clear_we,
  output logic [ADDRESS_BITS-1:0] clear_addr
);

  ram_state_t              state, state_next;
  logic [ADDRESS_BITS-1:0] count, count_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Leaving CLEAR is keyed on the last address, not on counter wrap.
  always_comb begin
    state_next = state;
    count_next = count;
    ready      = 1'b0;
    clear_we   = 1'b0;
    unique case (state)
      CLEAR: begin
        clear_we   = 1'b1;
        count_next = count + 1'b1;
        if (count == '1) state_next = RUN;
      end
      RUN: ready = 1'b1;
      default: state_next = CLEAR;
    endcase
  end

  assign clear_addr = count;

endmodule

// File: rtl/ram_dp_init.sv
// Dual-port synchronous RAM with lane write mask, selectable read-during-write
// behaviour and a hardware clear of every word after reset.
module ram_dp_init
  import ram_pkg::*;
#(
  parameter int unsigned          DATA_BITS    = 16,
  parameter int unsigned          LANE_BITS    = 8,
  parameter int unsigned          ADDRESS_BITS = 4,
  parameter int unsigned          RDW_MODE     = RDW_READ_FIRST,
  parameter logic [DATA_BITS-1:0] INIT_VALUE   = '0
) (
  input logic          clk,
  input logic          rst,
  ram_dp_init_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_BITS;

  logic [DATA_BITS-1:0]    mem [DEPTH];
  logic                    ready;
  logic                    clear_we;
  logic [ADDRESS_BITS-1:0] clear_addr;
  logic                    user_we;
  logic [DATA_BITS-1:0]    merged;
  logic                    wr_en;
  logic [ADDRESS_BITS-1:0] wr_addr;
  logic [DATA_BITS-1:0]    wr_data;

  ram_clear_seq #(
    .ADDRESS_BITS(ADDRESS_BITS)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .clear_we  (clear_we),
    .clear_addr(clear_addr)
  );

  assign bus.ready = ready;
  assign user_we   = bus.write && ready && (|bus.write_mask);
  assign merged    = DATA_BITS'(lane_merge(MAX_BITS'(mem[bus.write_addr]),
                                           MAX_BITS'(bus.in_data),
                                           MAX_BITS'(bus.write_mask),
                                           LANE_BITS));

  // Single physical write port shared by the clear sequencer and the user.
  always_comb begin
    wr_en   = clear_we;
    wr_addr = clear_addr;
    wr_data = INIT_VALUE;
    if (!clear_we && user_we) begin
      wr_en   = 1'b1;
      wr_addr = bus.write_addr;
      wr_data = merged;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (bus.read && ready) begin
        bus.out_valid <= 1'b1;
        if (RDW_MODE == RDW_WRITE_FIRST && user_we && bus.write_addr == bus.read_addr)
          bus.out_data <= merged;
        else
          bus.out_data <= mem[bus.read_addr];
      end
    end
  end

endmodule

// File: tb/tb_ram_dp_init.sv
// Directed bench for ram_dp_init: read-first, write-first and non-zero init variants.
module tb_ram_dp_init;

  logic        clk;
  logic        rst;
  logic        write;
  logic [3:0]  write_addr;
  logic [1:0]  write_mask;
  logic [15:0] in_data;
  logic        read;
  logic [3:0]  read_addr;

  int unsigned n_checks;
  int unsigned n_fail;
  logic [15:0] model [16];

  ram_dp_init_if #(.DATA_BITS(16), .LANE_BITS(8), .ADDRESS_BITS(4)) bus0 ();
  ram_dp_init_if #(.DATA_BITS(16), .LANE_BITS(8), .ADDRESS_BITS(4)) bus1 ();
  ram_dp_init_if #(.DATA_BITS(16), .LANE_BITS(8), .ADDRESS_BITS(4)) bus2 ();

  assign bus0.write = write;  assign bus1.write = write;  assign bus2.write = write;
  assign bus0.write_addr = write_addr;  assign bus1.write_addr = write_addr;
  assign bus2.write_addr = write_addr;
  assign bus0.write_mask = write_mask;  assign bus1.write_mask = write_mask;
  assign bus2.write_mask = write_mask;
  assign bus0.in_data = in_data;  assign bus1.in_data = in_data;  assign bus2.in_data = in_data;
  assign bus0.read = read;  assign bus1.read = read;  assign bus2.read = read;
  assign bus0.read_addr = read_addr;  assign bus1.read_addr = read_addr;
  assign bus2.read_addr = read_addr;

  ram_dp_init #(.DATA_BITS(16), .LANE_BITS(8), .ADDRESS_BITS(4), .RDW_MODE(0),
                .INIT_VALUE(16'h0000)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  ram_dp_init #(.DATA_BITS(16), .LANE_BITS(8), .ADDRESS_BITS(4), .RDW_MODE(1),
                .INIT_VALUE(16'h0000)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  ram_dp_init #(.DATA_BITS(16), .LANE_BITS(8), .ADDRESS_BITS(4), .RDW_MODE(0),
                .INIT_VALUE(16'hA5A5)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic w, input logic [3:0] wa, input logic [1:0] wm,
                       input logic [15:0] wd, input logic r, input logic [3:0] ra);
    write = w; write_addr = wa; write_mask = wm; in_data = wd;
    read = r;  read_addr = ra;
    @(posedge clk);
    #1;
    write = 1'b0; read = 1'b0;
  endtask

  task automatic model_write(input logic [3:0] a, input logic [1:0] m, input logic [15:0] d);
    if (m[0]) model[a][7:0]  = d[7:0];
    if (m[1]) model[a][15:8] = d[15:8];
  endtask

  // Count posedges until ready; optionally inject ignored requests at cycle 2.
  task automatic wait_ready(input string tag, input logic poke);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (poke && cnt == 2) begin
        write = 1'b1; write_addr = 4'd0; write_mask = 2'b11; in_data = 16'h5555;
        read = 1'b1;  read_addr = 4'd0;
      end
      @(posedge clk);
      #1;
      cnt++;
      if (poke && cnt == 3) begin
        check("clear_ignores_read", {31'd0, bus0.out_valid}, 32'd0);
        write = 1'b0; read = 1'b0;
      end
      if (bus0.ready) break;
    end
    check(tag, cnt, 32'd16);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    write = 1'b0; write_addr = '0; write_mask = '0; in_data = '0;
    read = 1'b0;  read_addr = '0;
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;

    #12;
    check("rst_ready", {31'd0, bus0.ready}, 32'd0);
    check("rst_valid", {31'd0, bus0.out_valid}, 32'd0);
    check("rst_data", {16'd0, bus0.out_data}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ready("clear_len", 1'b1);

    // Full readback after clear.
    for (int a = 0; a < 16; a++) begin
      cycle(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'(a));
      check("init_valid", {31'd0, bus0.out_valid}, 32'd1);
      check("init_data0", {16'd0, bus0.out_data}, 32'h0000);
      check("init_dataA5", {16'd0, bus2.out_data}, 32'hA5A5);
    end
    cycle(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0);
    check("idle_valid", {31'd0, bus0.out_valid}, 32'd0);
    check("idle_hold", {16'd0, bus2.out_data}, 32'hA5A5);

    // Lane mask merge.
    cycle(1'b1, 4'd3, 2'b11, 16'h1234, 1'b0, 4'd0); model_write(4'd3, 2'b11, 16'h1234);
    cycle(1'b1, 4'd3, 2'b01, 16'hFFEE, 1'b0, 4'd0); model_write(4'd3, 2'b01, 16'hFFEE);
    cycle(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd3);
    check("mask_merge", {16'd0, bus0.out_data}, 32'h12EE);
    cycle(1'b1, 4'd3, 2'b00, 16'hFFFF, 1'b0, 4'd0);
    cycle(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd3);
    check("mask_zero_noop", {16'd0, bus0.out_data}, 32'h12EE);

    // Same-address read during write.
    cycle(1'b1, 4'd7, 2'b11, 16'hBEEF, 1'b1, 4'd7); model_write(4'd7, 2'b11, 16'hBEEF);
    check("rdw_read_first", {16'd0, bus0.out_data}, 32'h0000);
    check("rdw_write_first", {16'd0, bus1.out_data}, 32'hBEEF);
    check("rdw_read_first_a5", {16'd0, bus2.out_data}, 32'hA5A5);
    cycle(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd7);
    check("rdw_after0", {16'd0, bus0.out_data}, 32'hBEEF);
    check("rdw_after1", {16'd0, bus1.out_data}, 32'hBEEF);
    cycle(1'b1, 4'd8, 2'b10, 16'h1122, 1'b1, 4'd8); model_write(4'd8, 2'b10, 16'h1122);
    check("rdw_partial0", {16'd0, bus0.out_data}, 32'h0000);
    check("rdw_partial1", {16'd0, bus1.out_data}, 32'h1100);

    // Streaming reads with crossing writes.
    for (int i = 0; i < 16; i++) begin
      logic [15:0] exp_d;
      exp_d = model[i];
      cycle(1'b1, 4'(15 - i), 2'b11, 16'hC000 | 16'(i), 1'b1, 4'(i));
      model_write(4'(15 - i), 2'b11, 16'hC000 | 16'(i));
      check("stream_valid", {31'd0, bus0.out_valid}, 32'd1);
      check("stream_data", {16'd0, bus0.out_data}, {16'd0, exp_d});
    end

    // Reset in RUN with a read result in flight, then mid-clear.
    cycle(1'b1, 4'd5, 2'b11, 16'h7777, 1'b0, 4'd0);
    cycle(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd5);
    check("pre_rst_data", {16'd0, bus0.out_data}, 32'h7777);
    rst = 1'b1;
    #1;
    check("run_rst_valid", {31'd0, bus0.out_valid}, 32'd0);
    check("run_rst_data", {16'd0, bus0.out_data}, 32'h0000);
    check("run_rst_ready", {31'd0, bus0.ready}, 32'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 9; i++) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, bus0.ready}, 32'd0);
    rst = 1'b0;
    wait_ready("reclear_len", 1'b0);
    cycle(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd5);
    check("reclear_addr5", {16'd0, bus0.out_data}, 32'h0000);
    cycle(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd0);
    check("reclear_addr0", {16'd0, bus0.out_data}, 32'h0000);
    check("reclear_a5", {16'd0, bus2.out_data}, 32'hA5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
